// File: rtl/rv_mem_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, owner tags and
// the default fetch-starvation limit.
package rv_mem_pkg;

  localparam int STARVE_MAX_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_MA = 1'b1
  } owner_e;

  // Width of a counter that must hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Owner selection: the data port wins ties unless fetch has already been
// passed over STARVE_LIM times in a row.
module mem_arb_pick
  import rv_mem_pkg::*;
#(
  parameter int              CW         = 3,
  parameter logic [CW-1:0]   STARVE_LIM = 3'd4
) (
  input  logic          if_req,
  input  logic          ma_req,
  input  logic [CW-1:0] starve_cnt,
  output logic          valid,
  output owner_e        owner
);

  always_comb begin
    valid = if_req | ma_req;
    if (if_req && (!ma_req || (starve_cnt == STARVE_LIM))) begin
      owner = OWN_IF;
    end else begin
      owner = OWN_MA;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Fetch/data arbiter in front of a single-port memory. One transaction is in
// flight at a time; request fields are captured at grant so requesters may move on.
module mem_arb
  import rv_mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ma_req,
  input  logic        ma_we,
  input  logic [31:0] ma_addr,
  input  logic [31:0] ma_wdata,
  output logic        ma_gnt,
  output logic        ma_rvalid,
  output logic [31:0] ma_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int            CW         = cnt_width(STARVE_MAX);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  arb_state_e    state_q,  state_d;
  owner_e        owner_q,  owner_d;
  logic          we_q,     we_d;
  logic [31:0]   addr_q,   addr_d;
  logic [31:0]   wdata_q,  wdata_d;
  logic [CW-1:0] starve_q, starve_d;

  logic   pick_valid;
  owner_e pick_owner;
  logic   grant;
  logic   resp;

  mem_arb_pick #(
    .CW         (CW),
    .STARVE_LIM (STARVE_LIM)
  ) u_pick (
    .if_req     (if_req),
    .ma_req     (ma_req),
    .starve_cnt (starve_q),
    .valid      (pick_valid),
    .owner      (pick_owner)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_owner;
          state_d = REQ;
          if (pick_owner == OWN_IF) begin
            we_d     = 1'b0;
            addr_d   = if_addr;
            wdata_d  = '0;
            starve_d = '0;
          end else begin
            we_d    = ma_we;
            addr_d  = ma_addr;
            wdata_d = ma_wdata;
            if (if_req && (starve_q != STARVE_LIM)) begin
              starve_d = starve_q + CW'(1);
            end
          end
        end
      end
      REQ: begin
        if (mem_gnt) state_d = RESP;
      end
      RESP: begin
        if (mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state, including the captured request, resets so a response
  // arriving after a mid-transaction reset finds the FSM idle and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
    end
  end

  // Grants are combinational from IDLE; masked by rst_n so they stay low in reset.
  assign grant     = rst_n && (state_q == IDLE) && pick_valid;
  assign if_gnt    = grant && (pick_owner == OWN_IF);
  assign ma_gnt    = grant && (pick_owner == OWN_MA);

  assign resp      = (state_q == RESP) && mem_rvalid;
  assign if_rvalid = resp && (owner_q == OWN_IF);
  assign ma_rvalid = resp && (owner_q == OWN_MA);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ma_rdata  = ma_rvalid ? mem_rdata : '0;

  assign mem_req   = (state_q == REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios plus a randomized run checked against a
// transaction-level model with its own backing memory.
module tb_mem_arb;

  localparam int SM = 4;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ma_req;
  logic        ma_we;
  logic [31:0] ma_addr;
  logic [31:0] ma_wdata;
  logic        ma_gnt;
  logic        ma_rvalid;
  logic [31:0] ma_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mm [logic [31:0]];

  mem_arb #(.STARVE_MAX(SM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .ma_req     (ma_req),
    .ma_we      (ma_we),
    .ma_addr    (ma_addr),
    .ma_wdata   (ma_wdata),
    .ma_gnt     (ma_gnt),
    .ma_rvalid  (ma_rvalid),
    .ma_rdata   (ma_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req     = 1'b0;
    if_addr    = '0;
    ma_req     = 1'b0;
    ma_we      = 1'b0;
    ma_addr    = '0;
    ma_wdata   = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (mm.exists(a)) return mm[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rnd_addr();
    return 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
  endfunction

  task automatic test_reset();
    if_req = 1'b1; ma_req = 1'b1; ma_we = 1'b1;
    if_addr = 32'h44; ma_addr = 32'h88; ma_wdata = 32'hFFFF_FFFF;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({if_gnt, if_rvalid, if_rdata, ma_gnt, ma_rvalid, ma_rdata,
         mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {if_gnt, if_rvalid, if_rdata, ma_gnt,
               ma_rvalid, ma_rdata, mem_req, mem_we, mem_addr, mem_wdata});
    end
    tick();
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({if_gnt, ma_gnt, mem_req} !== 3'b000) begin
      errors++; $display("FAIL reset_release_idle: got %b want 000", {if_gnt, ma_gnt, mem_req});
    end
  endtask

  task automatic test_single_fetch();
    tick();
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    checks++;
    if ({if_gnt, ma_gnt, mem_req} !== 3'b100) begin
      errors++; $display("FAIL fetch_gnt: got %b want 100", {if_gnt, ma_gnt, mem_req});
    end
    tick();
    if_req = 1'b0; if_addr = 32'hBAD0_0000; mem_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      errors++; $display("FAIL fetch_mem_req: got %b/%b/%h want 1/0/00000100", mem_req, mem_we, mem_addr);
    end
    tick();
    mem_gnt = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if ({mem_req, if_rvalid, if_rdata} !== '0) begin
      errors++; $display("FAIL fetch_wait: got %b/%b/%h want 0/0/0", mem_req, if_rvalid, if_rdata);
    end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_rdata, ma_rvalid} !== {1'b1, 32'h0050_0093, 1'b0}) begin
      errors++; $display("FAIL fetch_rvalid: got %b/%h/%b want 1/00500093/0", if_rvalid, if_rdata, ma_rvalid);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_write_stall();
    tick();
    ma_req = 1'b1; ma_we = 1'b1; ma_addr = 32'h2000; ma_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({ma_gnt, if_gnt} !== 2'b10) begin
      errors++; $display("FAIL write_gnt: got %b want 10", {ma_gnt, if_gnt});
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      ma_req = 1'b0; ma_we = $urandom_range(0, 1); ma_addr = $urandom; ma_wdata = $urandom;
      mem_gnt = (c == 3);
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF}) begin
        errors++; $display("FAIL write_stable[%0d]: got %b/%b/%h/%h want 1/1/00002000/deadbeef",
                           c, mem_req, mem_we, mem_addr, mem_wdata);
      end
    end
    tick();
    mem_gnt = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, ma_rvalid} !== 2'b00) begin
      errors++; $display("FAIL write_resp_wait: got %b want 00", {mem_req, ma_rvalid});
    end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0;
    @(negedge clk);
    checks++;
    if ({ma_rvalid, ma_rdata, if_rvalid} !== {1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL write_rvalid: got %b/%h/%b want 1/0/0", ma_rvalid, ma_rdata, if_rvalid);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_early_drop();
    tick();
    ma_req = 1'b1; ma_we = 1'b0; ma_addr = 32'h3000;
    @(negedge clk);
    checks++;
    if (ma_gnt !== 1'b1) begin
      errors++; $display("FAIL drop_gnt: got %b want 1", ma_gnt);
    end
    tick();
    ma_req = 1'b0; ma_addr = 32'hFFFF;
    @(negedge clk);
    checks++;
    if ({ma_gnt, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h3000}) begin
      errors++; $display("FAIL drop_addr_hold: got %b/%b/%h want 0/1/00003000", ma_gnt, mem_req, mem_addr);
    end
    tick();
    mem_gnt = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h3000}) begin
      errors++; $display("FAIL drop_addr_gnt: got %b/%h want 1/00003000", mem_req, mem_addr);
    end
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55;
    @(negedge clk);
    checks++;
    if ({ma_rvalid, ma_rdata} !== {1'b1, 32'h55}) begin
      errors++; $display("FAIL drop_rvalid: got %b/%h want 1/00000055", ma_rvalid, ma_rdata);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_contention();
    int  k;
    bit  exp_if;
    k = 0;
    tick();
    if_req = 1'b1; ma_req = 1'b1; if_addr = 32'h40; ma_addr = 32'h80;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0;
    for (int c = 0; c < 60 && k < 10; c++) begin
      @(negedge clk);
      if (if_gnt || ma_gnt) begin
        exp_if = ((k % (SM + 1)) == SM);
        checks++;
        if ({if_gnt, ma_gnt} !== {exp_if, !exp_if}) begin
          errors++; $display("FAIL contention_order[%0d]: got if/ma=%b%b want %b%b",
                             k, if_gnt, ma_gnt, exp_if, !exp_if);
        end
        k++;
      end
      tick();
    end
    checks++;
    if (k != 10) begin
      errors++; $display("FAIL contention_timeout: got %0d grants want 10", k);
    end
    if_req = 1'b0; ma_req = 1'b0;
    repeat (3) tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_resp();
    tick();
    ma_req = 1'b1; ma_addr = 32'h500;
    @(negedge clk);
    checks++;
    if (ma_gnt !== 1'b1) begin
      errors++; $display("FAIL rst_mid_gnt: got %b want 1", ma_gnt);
    end
    tick();
    ma_req = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, ma_rvalid} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_in_resp: got %b want 00", {mem_req, ma_rvalid});
    end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_gnt, if_rvalid, ma_gnt, ma_rvalid, mem_req, mem_addr} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got %b%b%b%b%b/%h want 0", if_gnt, if_rvalid,
                         ma_gnt, ma_rvalid, mem_req, mem_addr);
    end
    tick();
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
    @(negedge clk);
    checks++;
    if ({if_rvalid, ma_rvalid, if_rdata, ma_rdata} !== '0) begin
      errors++; $display("FAIL rst_mid_dropped: got %b/%b/%h/%h want 0", if_rvalid, ma_rvalid, if_rdata, ma_rdata);
    end
    tick();
    mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h600;
    @(negedge clk);
    checks++;
    if ({if_gnt, mem_req} !== 2'b10) begin
      errors++; $display("FAIL rst_mid_idle: got %b want 10", {if_gnt, mem_req});
    end
    tick();
    if_req = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h77}) begin
      errors++; $display("FAIL rst_mid_recover: got %b/%h want 1/00000077", if_rvalid, if_rdata);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    bit          m_pend, m_wait, m_is_if, m_we;
    logic [31:0] m_addr, m_wdata, e_rdata;
    int          m_starve;
    bit          e_idle, e_if_gnt, e_ma_gnt, e_resp;
    int          if_grants, ma_grants;
    m_pend = 0; m_wait = 0; m_is_if = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_starve = 0;
    if_grants = 0; ma_grants = 0;
    for (int c = 0; c < 800; c++) begin
      tick();
      if_req     = ($urandom_range(0, 99) < 55);
      if_addr    = rnd_addr();
      ma_req     = ($urandom_range(0, 99) < 70);
      ma_we      = $urandom_range(0, 1);
      ma_addr    = rnd_addr();
      ma_wdata   = $urandom;
      mem_gnt    = $urandom_range(0, 1);
      mem_rvalid = ($urandom_range(0, 2) == 0);
      if (m_wait) mem_rdata = m_we ? 32'h0 : model_read(m_addr);
      else        mem_rdata = $urandom;
      @(negedge clk);
      e_idle   = !m_pend && !m_wait;
      e_if_gnt = e_idle && if_req && (!ma_req || m_starve == SM);
      e_ma_gnt = e_idle && ma_req && !e_if_gnt;
      e_resp   = m_wait && mem_rvalid;
      e_rdata  = m_we ? 32'h0 : model_read(m_addr);
      checks++;
      if ({if_gnt, ma_gnt, mem_req} !== {e_if_gnt, e_ma_gnt, m_pend}) begin
        errors++; $display("FAIL rand_ctrl[%0d]: got gnt/req %b%b%b want %b%b%b", c,
                           if_gnt, ma_gnt, mem_req, e_if_gnt, e_ma_gnt, m_pend);
      end
      if (m_pend) begin
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {m_we, m_addr, m_wdata}) begin
          errors++; $display("FAIL rand_mem_fields[%0d]: got %b/%h/%h want %b/%h/%h", c,
                             mem_we, mem_addr, mem_wdata, m_we, m_addr, m_wdata);
        end
      end
      checks++;
      if ({if_rvalid, if_rdata, ma_rvalid, ma_rdata} !==
          {e_resp && m_is_if, (e_resp && m_is_if) ? e_rdata : 32'h0,
           e_resp && !m_is_if, (e_resp && !m_is_if) ? e_rdata : 32'h0}) begin
        errors++; $display("FAIL rand_resp[%0d]: got if %b/%h ma %b/%h want valid=%b owner_if=%b data=%h",
                           c, if_rvalid, if_rdata, ma_rvalid, ma_rdata, e_resp, m_is_if, e_rdata);
      end
      if (e_resp) begin
        if (m_we) mm[m_addr] = m_wdata;
        m_wait = 0;
      end else if (m_pend && mem_gnt) begin
        m_pend = 0; m_wait = 1;
      end else if (e_if_gnt) begin
        m_is_if = 1; m_we = 0; m_addr = if_addr; m_wdata = '0; m_pend = 1; m_starve = 0;
        if_grants++;
      end else if (e_ma_gnt) begin
        m_is_if = 0; m_we = ma_we; m_addr = ma_addr; m_wdata = ma_wdata; m_pend = 1;
        if (if_req && m_starve < SM) m_starve++;
        ma_grants++;
      end
    end
    checks++;
    if (if_grants == 0 || ma_grants == 0) begin
      errors++; $display("FAIL rand_coverage: got if=%0d ma=%0d grants want both nonzero", if_grants, ma_grants);
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_write_stall();
    test_early_drop();
    test_contention();
    test_reset_mid_resp();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
